victory_anim: RTL

VICTORY_ANIM -- requirements
Module: victory_anim

---
 rtl/victory_anim.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/victory_anim.sv
// Purpose: end-of-game LED animation (blink, sweep, bounce) that passes the live rope score through while idle.
// Latency: the first pattern appears the cycle after wingame is seen in IDLE; each later step waits for a slowen tick.
// Backpressure: none; wingame/win_right/mode are ignored while busy and during the done cycle.
//
// Ports: clk, rst (sync, active-high); slowen (tick enable); wingame/win_right/mode (start request, side, pattern);
//        score (idle pass-through); victory_led (LED drive); busy (animation running); done (final-loop pulse).
module victory_anim #(
    parameter int N_LEDS   = 7,
    parameter int BLOCK_W  = 3,
    parameter int N_BLINKS = 2,
    parameter int N_LOOPS  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              slowen,
    input  logic              wingame,
    input  logic              win_right,
    input  logic [1:0]        mode,
    input  logic [N_LEDS-1:0] score,
    output logic [N_LEDS-1:0] victory_led,
    output logic              busy,
    output logic              done
);

    localparam int C  = (N_LEDS - 1) / 2;
    localparam int PW = $clog2(N_LEDS);

    localparam logic [PW-1:0]     POS_C      = PW'(C);
    localparam logic [PW-1:0]     POS_CM1    = PW'(C - 1);
    localparam logic [PW-1:0]     POS_CP1    = PW'(C + 1);
    localparam logic [PW-1:0]     POS_TOP    = PW'(N_LEDS - 1);
    localparam logic [PW-1:0]     POS_TOPM1  = PW'(N_LEDS - 2);
    localparam logic [3:0]        BLINK_LAST = 4'(N_BLINKS - 1);
    localparam logic [7:0]        LOOP_INIT  = 8'(N_LOOPS);
    localparam logic [N_LEDS-1:0] LED_ONE    = {{(N_LEDS-1){1'b0}}, 1'b1};
    localparam logic [N_LEDS-1:0] RIGHT_BLK  = {{(N_LEDS-BLOCK_W){1'b0}}, {BLOCK_W{1'b1}}};
    localparam logic [N_LEDS-1:0] LEFT_BLK   = {{BLOCK_W{1'b1}}, {(N_LEDS-BLOCK_W){1'b0}}};
    // With only one LED per side the return sweep would be empty, so bounce ends at the far LED.
    localparam bit                HAS_BACK   = (C > 1);

    typedef enum logic [2:0] {
        IDLE,
        BLINK_ON,
        BLINK_OFF,
        CENTER,
        SWEEP_OUT,
        SWEEP_BACK
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] pos, pos_nxt;
    logic [3:0]    blink_cnt, blink_nxt;
    logic [7:0]    loop_cnt, loop_nxt;
    logic          side_r, side_nxt;
    logic [1:0]    mode_r, mode_nxt;
    logic          done_nxt;
    logic          loop_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pos       <= '0;
            blink_cnt <= '0;
            loop_cnt  <= '0;
            side_r    <= 1'b0;
            mode_r    <= 2'd0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            pos       <= pos_nxt;
            blink_cnt <= blink_nxt;
            loop_cnt  <= loop_nxt;
            side_r    <= side_nxt;
            mode_r    <= mode_nxt;
            done      <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pos_nxt     = pos;
        blink_nxt   = blink_cnt;
        loop_nxt    = loop_cnt;
        side_nxt    = side_r;
        mode_nxt    = mode_r;
        done_nxt    = 1'b0;
        loop_end    = 1'b0;
        busy        = 1'b1;
        victory_led = LED_ONE << pos;

        case (state)
            IDLE: begin
                victory_led = score;
                busy        = 1'b0;
                // done high marks the cycle just after a finished run; a start is only taken after it.
                if (wingame && !done) begin
                    side_nxt  = win_right;
                    mode_nxt  = mode;
                    loop_nxt  = LOOP_INIT;
                    blink_nxt = '0;
                    pos_nxt   = POS_C;
                    state_nxt = mode[1] ? CENTER : BLINK_ON;
                end
            end
            BLINK_ON: begin
                victory_led = side_r ? RIGHT_BLK : LEFT_BLK;
                if (slowen) state_nxt = BLINK_OFF;
            end
            BLINK_OFF: begin
                victory_led = '0;
                if (slowen) begin
                    if (blink_cnt == BLINK_LAST) begin
                        if (mode_r == 2'd0) begin
                            pos_nxt   = POS_C;
                            state_nxt = CENTER;
                        end else begin
                            loop_end = 1'b1;
                        end
                    end else begin
                        blink_nxt = blink_cnt + 4'd1;
                        state_nxt = BLINK_ON;
                    end
                end
            end
            CENTER: begin
                if (slowen) begin
                    pos_nxt   = side_r ? POS_CM1 : POS_CP1;
                    state_nxt = SWEEP_OUT;
                end
            end
            SWEEP_OUT: begin
                if (slowen) begin
                    if (pos == (side_r ? '0 : POS_TOP)) begin
                        if (mode_r == 2'd3 && HAS_BACK) begin
                            pos_nxt   = side_r ? PW'(1) : POS_TOPM1;
                            state_nxt = SWEEP_BACK;
                        end else begin
                            loop_end = 1'b1;
                        end
                    end else begin
                        pos_nxt = side_r ? pos - PW'(1) : pos + PW'(1);
                    end
                end
            end
            SWEEP_BACK: begin
                if (slowen) begin
                    if (pos == (side_r ? POS_CM1 : POS_CP1)) begin
                        loop_end = 1'b1;
                    end else begin
                        pos_nxt = side_r ? pos + PW'(1) : pos - PW'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Loop wrap happens on the same tick as the last step, so loops run back to back.
        if (loop_end) begin
            blink_nxt = '0;
            pos_nxt   = POS_C;
            if (N_LOOPS == 0 || loop_cnt > 8'd1) begin
                if (N_LOOPS != 0) loop_nxt = loop_cnt - 8'd1;
                state_nxt = mode_r[1] ? CENTER : BLINK_ON;
            end else begin
                loop_nxt  = '0;
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
        end
    end

endmodule
